tnn_sum_cmp_seq: RTL

TNN_SUM_CMP_SEQ -- requirements
Module: tnn_sum_cmp_seq

---
 rtl/tnn_sum_cmp_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tnn_sum_cmp_seq.sv
// Sequential ternary-network node: sums N unsigned addends one per cycle and
// compares the total against a threshold, returning the decision bit over a valid/ready pair.
module tnn_sum_cmp_seq #(
    parameter int W = 3,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_addends,
    input  logic [W-1:0]   in_thresh,
    input  logic           in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_result,
    output logic           busy
);

    localparam int SW = W + $clog2(N);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rst_sync_n;
    logic [W-1:0]  addend_q [N];
    logic [W-1:0]  thresh_q;
    logic          mode_q;
    logic [SW-1:0] acc_q;
    logic [IW-1:0] idx_q;
    logic          result_q;

    logic [W-1:0]  addend_cur;
    logic [SW-1:0] sum_next;
    logic [SW-1:0] thresh_ext;
    logic          last_add;
    logic          cmp_bit;

    // Assertion is immediate; release waits one clock so that no state flop
    // leaves reset on a partially settled edge.
    // NOTE: flops always use non-blocking assignment so every register samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_n <= 1'b0;
        else        rst_sync_n <= 1'b1;
    end

    generate
        if (N == 1) begin : g_single
            assign addend_cur = addend_q[0];
        end else begin : g_multi
            assign addend_cur = addend_q[idx_q];
        end
    endgenerate

    assign sum_next   = acc_q + SW'(addend_cur);
    assign thresh_ext = SW'(thresh_q);
    assign last_add   = (idx_q == LAST_IDX);
    assign cmp_bit    = mode_q ? (thresh_ext >= sum_next) : (thresh_ext > sum_next);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = ACC;
            end
            ACC: begin
                if (last_add) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                ACC: begin
                    acc_q <= sum_next;
                    idx_q <= idx_q + IW'(1);
                    if (last_add) result_q <= cmp_bit;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the sample payload is not reset; it is only read after a fresh
    // capture in IDLE, so resetting it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            for (int i = 0; i < N; i++) addend_q[i] <= in_addends[i*W +: W];
            thresh_q <= in_thresh;
            mode_q   <= in_mode;
        end
    end

    assign out_result = result_q;

endmodule
